// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single port of the on-chip fast memory
// between the instruction-fetch unit and the load/store unit. One request
// is latched at a time, the memory is driven for exactly one ACCESS cycle,
// and the winner receives registered read data with a one-cycle ack in RESP.
// Data has priority, capped by a streak counter so that fetch keeps making
// progress. Misaligned or out-of-range addresses are flagged and never write.
module mem_port_arbiter #(
  parameter int NUM_OF_BYTES = 1024,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch requester
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  // load/store requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory port
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  // status
  output logic        busy
);

  localparam logic [31:0] LAST_ADDR_C  = 32'(NUM_OF_BYTES - 4);
  localparam logic [3:0]  MAX_STREAK_C = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Address legality: word aligned and inside the attached memory.
  function automatic logic addr_err_f(input logic [31:0] addr);
    addr_err_f = (addr[1:0] != 2'b00) || (addr > LAST_ADDR_C);
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  streak_r;
  logic [3:0]  streak_nxt_s;
  logic        grant_d_s;
  logic        grant_i_s;
  logic [31:0] sel_addr_s;

  // Latched transaction (what the memory sees during ACCESS).
  logic [31:0] addr_r;
  logic        we_r;
  logic [31:0] wdata_r;
  logic        src_d_r;   // 1 = data requester won, 0 = fetch won
  logic        err_r;
  logic        mem_we_r;

  // State register and data-streak counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      streak_r <= 4'd0;
    end else begin
      state_r  <= state_nxt_s;
      streak_r <= streak_nxt_s;
    end
  end

  // Next-state, arbitration and streak update; requests are looked at only in IDLE.
  always_comb begin
    state_nxt_s  = state_r;
    streak_nxt_s = streak_r;
    grant_d_s    = 1'b0;
    grant_i_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Data wins unless fetch is waiting and the streak has hit its cap.
        if (d_req && (!i_req || (streak_r != MAX_STREAK_C))) begin
          grant_d_s = 1'b1;
        end else begin
          grant_d_s = 1'b0;
        end
        if (i_req && !grant_d_s) begin
          grant_i_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
        end
        if (grant_d_s || grant_i_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
        // Streak counts data grants that made fetch wait; anything else resets it.
        if (grant_d_s && i_req) begin
          if (streak_r < MAX_STREAK_C) begin
            streak_nxt_s = streak_r + 4'd1;
          end else begin
            streak_nxt_s = streak_r;
          end
        end else if (grant_i_s || !i_req) begin
          streak_nxt_s = 4'd0;
        end else begin
          streak_nxt_s = streak_r;
        end
      end
      ST_ACCESS: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Address of whichever requester is being granted this cycle.
  always_comb begin
    sel_addr_s = 32'h0000_0000;
    if (grant_d_s) begin
      sel_addr_s = d_addr;
    end else begin
      sel_addr_s = i_addr;
    end
  end

  // Latch the winning transaction at grant; write enable lives only for ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r   <= 32'h0000_0000;
      we_r     <= 1'b0;
      wdata_r  <= 32'h0000_0000;
      src_d_r  <= 1'b0;
      err_r    <= 1'b0;
      mem_we_r <= 1'b0;
    end else if (grant_d_s || grant_i_s) begin
      addr_r   <= sel_addr_s;
      we_r     <= grant_d_s & d_we;
      wdata_r  <= grant_d_s ? d_wdata : 32'h0000_0000;
      src_d_r  <= grant_d_s;
      err_r    <= addr_err_f(sel_addr_s);
      // Erroneous stores never reach the memory.
      mem_we_r <= grant_d_s & d_we & ~addr_err_f(sel_addr_s);
    end else begin
      mem_we_r <= 1'b0;
    end
  end

  // Capture read data at the end of ACCESS; stores and errors return zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata <= 32'h0000_0000;
      d_rdata <= 32'h0000_0000;
    end else if (state_r == ST_ACCESS) begin
      if (src_d_r) begin
        d_rdata <= (we_r || err_r) ? 32'h0000_0000 : mem_read_data;
      end else begin
        i_rdata <= err_r ? 32'h0000_0000 : mem_read_data;
      end
    end else begin
      i_rdata <= i_rdata;
      d_rdata <= d_rdata;
    end
  end

  // Ack/err pulses for the winner during RESP only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      i_err <= 1'b0;
      d_err <= 1'b0;
    end else begin
      i_ack <= (state_r == ST_ACCESS) && !src_d_r;
      d_ack <= (state_r == ST_ACCESS) &&  src_d_r;
      i_err <= (state_r == ST_ACCESS) && !src_d_r && err_r;
      d_err <= (state_r == ST_ACCESS) &&  src_d_r && err_r;
    end
  end

  assign mem_address    = addr_r;
  assign mem_write_data = wdata_r;
  assign mem_write_en   = mem_we_r;
  assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus tasks push the expected
// response of each request into a queue; an independent monitor pops and
// compares whenever the DUT acks. A small behavioural memory sits on the port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;

  mem_port_arbiter #(.NUM_OF_BYTES(1024), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural 1 KiB memory: combinational read, write on posedge.
  logic [31:0] mem [0:255];
  int wr_cnt = 0;
  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_address[9:2]] <= mem_write_data;
      wr_cnt++;
    end
  end

  typedef struct packed {
    logic        src_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endfunction

  // Monitor: every ack is matched against the oldest expectation.
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      chk(!(i_ack && d_ack), "single_ack", {30'h0, i_ack, d_ack}, 32'h1);
      chk(exp_q.size() != 0, "ack_expected", 32'(exp_q.size()), 32'h1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk(d_ack == e.src_d, "ack_source", {31'h0, d_ack}, {31'h0, e.src_d});
        if (e.src_d) begin
          chk(d_rdata == e.rdata, "d_rdata", d_rdata, e.rdata);
          chk(d_err == e.err, "d_err", {31'h0, d_err}, {31'h0, e.err});
        end else begin
          chk(i_rdata == e.rdata, "i_rdata", i_rdata, e.rdata);
          chk(i_err == e.err, "i_err", {31'h0, i_err}, {31'h0, e.err});
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk(!i_ack && !d_ack && !i_err && !d_err, {tag, "_ack_err"},
        {28'h0, i_ack, d_ack, i_err, d_err}, 32'h0);
    chk(i_rdata == 32'h0, {tag, "_i_rdata"}, i_rdata, 32'h0);
    chk(d_rdata == 32'h0, {tag, "_d_rdata"}, d_rdata, 32'h0);
    chk(mem_address == 32'h0 && mem_write_data == 32'h0, {tag, "_mem_bus"},
        mem_address | mem_write_data, 32'h0);
    chk(!mem_write_en && !busy, {tag, "_we_busy"}, {30'h0, mem_write_en, busy}, 32'h0);
  endtask

  // One request from IDLE: expect ACCESS next cycle, ack the cycle after.
  task automatic run_req(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input bit exp_err, input bit exp_we);
    int lat;
    bit got;
    exp_q.push_back('{is_d, exp_rdata, exp_err});
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        chk(busy == 1'b1, "busy_access", {31'h0, busy}, 32'h1);
        chk(mem_write_en == exp_we, "we_access", {31'h0, mem_write_en}, {31'h0, exp_we});
      end
      got = is_d ? d_ack : i_ack;
    end
    chk(got && lat == 2, "latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    i_req = 1'b0;
    d_req = 1'b0;
    chk(!mem_write_en && !busy, "idle_after", {30'h0, mem_write_en, busy}, 32'h0);
  endtask

  initial begin
    int wr0;
    int n_ack;
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[2] <= 32'hE1A0_0000;
    mem[8] <= 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Fetch only
    wr0 = wr_cnt;
    run_req(1'b0, 1'b0, 32'h8, 32'h0, 32'hE1A0_0000, 1'b0, 1'b0);
    chk(wr_cnt == wr0, "fetch_no_write", 32'(wr_cnt - wr0), 32'h0);

    // Store then load
    wr0 = wr_cnt;
    run_req(1'b1, 1'b1, 32'h10, 32'h0000_0014, 32'h0, 1'b0, 1'b1);
    chk(wr_cnt == wr0 + 1, "store_one_write", 32'(wr_cnt - wr0), 32'h1);
    chk(mem[4] == 32'h0000_0014, "store_mem", mem[4], 32'h0000_0014);
    run_req(1'b1, 1'b0, 32'h10, 32'h0, 32'h0000_0014, 1'b0, 1'b0);

    // Errors: misaligned load, out-of-range store
    wr0 = wr_cnt;
    run_req(1'b1, 1'b0, 32'h3FE, 32'h0, 32'h0, 1'b1, 1'b0);
    run_req(1'b1, 1'b1, 32'h400, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    chk(wr_cnt == wr0, "err_no_write", 32'(wr_cnt - wr0), 32'h0);
    chk(mem[0] == 32'h0, "err_mem_untouched", mem[0], 32'h0);
    chk(mem[255] == 32'h0, "err_mem_top_untouched", mem[255], 32'h0);

    // Contention: both held high -> D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) exp_q.push_back('{1'b0, 32'hE1A0_0000, 1'b0});
      else                  exp_q.push_back('{1'b1, 32'h0000_0014, 1'b0});
    end
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    n_ack = 0;
    for (int c = 0; c < 60 && n_ack < 10; c++) begin
      @(posedge clk); #1;
      if (i_ack || d_ack) n_ack++;
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    d_req = 1'b0;
    chk(n_ack == 10, "contention_acks", 32'(n_ack), 32'd10);
    chk(exp_q.size() == 0, "contention_drain", 32'(exp_q.size()), 32'h0);

    // Reset during a store in ACCESS
    wr0 = wr_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    chk(mem_write_en == 1'b1, "abort_we_before", {31'h0, mem_write_en}, 32'h1);
    #2;
    reset = 1'b1;
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'h8;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    chk(mem[8] == 32'hDEAD_BEEF, "abort_mem", mem[8], 32'hDEAD_BEEF);
    chk(wr_cnt == wr0, "abort_no_write", 32'(wr_cnt - wr0), 32'h0);
    run_req(1'b0, 1'b0, 32'h8, 32'h0, 32'hE1A0_0000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "final_drain", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
